// File: rtl/lane_spawner.sv
`default_nettype none
// ============================================================================
//  Module   : lane_spawner
//  Purpose  : One Frogger lane: shifting car-occupancy row fed by LFSR bits,
//             with gap/length-controlled car spawning and frog collision flag.
//  Revision : 1.0  initial release
// ============================================================================
module lane_spawner #(
    parameter int WIDTH       = 16,
    parameter int COL_W       = 4,
    parameter int PERIOD_BASE = 12500000,
    parameter int MIN_GAP     = 3,
    parameter int CAR_LEN     = 2,
    parameter int DENSITY     = 96,
    parameter int DIR         = 0
) (
    input  logic             clock,
    input  logic             reset,
    input  logic             enable,
    input  logic [15:0]      rand_in,
    input  logic [1:0]       speed_sel,
    input  logic [COL_W-1:0] frog_col,
    input  logic             frog_in_lane,
    output logic [WIDTH-1:0] row,
    output logic             hit,
    output logic             tick_out
);

    localparam int c_div_w = (4 * PERIOD_BASE > 1) ? $clog2(4 * PERIOD_BASE) : 1;
    localparam int c_lim_w = $clog2(4 * PERIOD_BASE + 1);
    localparam int c_ext_w = 2 ** COL_W;

    localparam logic [3:0] c_min_gap = 4'(MIN_GAP);
    localparam logic [3:0] c_car_len = 4'(CAR_LEN);
    localparam logic [8:0] c_density = 9'(DENSITY);

    typedef enum logic [0:0] {
        ST_GAP = 1'b0,
        ST_CAR = 1'b1
    } state_t;

    state_t               state_q, state_d;
    logic [c_div_w-1:0]   div_q, div_d;
    logic [c_lim_w-1:0]   limit_q, limit_d;
    logic [WIDTH-1:0]     row_q, row_d;
    logic [3:0]           gap_q, gap_d;
    logic [3:0]           run_q, run_d;
    logic                 hit_q, hit_d;
    logic                 tick_q, tick_d;

    logic                 w_tick;
    logic                 w_dense;
    logic                 w_ins;
    logic [c_ext_w-1:0]   w_row_ext;
    logic                 w_unused_rand;

    function automatic logic [c_lim_w-1:0] limit_for(input logic [1:0] sel);
        logic [c_lim_w-1:0] lim;
        case (sel)
            2'd0:    lim = c_lim_w'(4 * PERIOD_BASE);
            2'd1:    lim = c_lim_w'(3 * PERIOD_BASE);
            2'd2:    lim = c_lim_w'(2 * PERIOD_BASE);
            default: lim = c_lim_w'(PERIOD_BASE);
        endcase
        return lim;
    endfunction

    assign w_tick        = enable && (c_lim_w'(div_q) == (limit_q - c_lim_w'(1)));
    assign w_dense       = ({1'b0, rand_in[7:0]} < c_density);
    assign w_unused_rand = ^rand_in[15:8];
    // Zero-extend so any frog_col beyond the lane reads an empty column.
    assign w_row_ext     = c_ext_w'(row_q);

    always_comb begin
        div_d   = div_q;
        limit_d = limit_q;
        row_d   = row_q;
        state_d = state_q;
        gap_d   = gap_q;
        run_d   = run_q;
        w_ins   = 1'b0;
        tick_d  = w_tick;
        hit_d   = frog_in_lane & w_row_ext[frog_col];

        if (enable) begin
            div_d = w_tick ? '0 : div_q + c_div_w'(1);
        end

        if (w_tick) begin
            limit_d = limit_for(speed_sel);
            case (state_q)
                ST_GAP: begin
                    if ((gap_q >= c_min_gap) && w_dense) begin
                        w_ins = 1'b1;
                        run_d = 4'd1;
                        if (CAR_LEN == 1) begin
                            gap_d = 4'd0;
                        end else begin
                            state_d = ST_CAR;
                        end
                    end else if (gap_q != 4'hF) begin
                        gap_d = gap_q + 4'd1;
                    end
                end
                ST_CAR: begin
                    w_ins = 1'b1;
                    run_d = run_q + 4'd1;
                    if ((run_q + 4'd1) == c_car_len) begin
                        state_d = ST_GAP;
                        gap_d   = 4'd0;
                    end
                end
                default: state_d = ST_GAP;
            endcase

            if (DIR == 0) begin
                row_d = {w_ins, row_q[WIDTH-1:1]};
            end else begin
                row_d = {row_q[WIDTH-2:0], w_ins};
            end
        end
    end

    always_ff @(posedge clock) begin
        if (reset) begin
            state_q <= ST_GAP;
            div_q   <= '0;
            limit_q <= limit_for(speed_sel);
            row_q   <= '0;
            gap_q   <= 4'd0;
            run_q   <= 4'd0;
            hit_q   <= 1'b0;
            tick_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            div_q   <= div_d;
            limit_q <= limit_d;
            row_q   <= row_d;
            gap_q   <= gap_d;
            run_q   <= run_d;
            hit_q   <= hit_d;
            tick_q  <= tick_d;
        end
    end

    assign row      = row_q;
    assign hit      = hit_q;
    assign tick_out = tick_q;

endmodule
`default_nettype wire

// File: tb/tb_lane_spawner.sv
`default_nettype none
// ============================================================================
//  Module   : tb_lane_spawner
//  Purpose  : Directed self-checking bench for lane_spawner (both directions).
//  Revision : 1.0  initial release
// ============================================================================
module tb_lane_spawner;

    logic        clock = 1'b0;
    logic        reset;
    logic        enable;
    logic [15:0] rand_in;
    logic [1:0]  speed_sel;
    logic [2:0]  frog_col;
    logic        frog_in_lane;
    logic [7:0]  row, row_r;
    logic        hit, hit_r;
    logic        tick_out, tick_out_r;

    int errors = 0;
    int checks = 0;

    always #5 clock = ~clock;

    lane_spawner #(
        .WIDTH(8), .COL_W(3), .PERIOD_BASE(4), .MIN_GAP(2),
        .CAR_LEN(2), .DENSITY(128), .DIR(0)
    ) dut (
        .clock(clock), .reset(reset), .enable(enable), .rand_in(rand_in),
        .speed_sel(speed_sel), .frog_col(frog_col), .frog_in_lane(frog_in_lane),
        .row(row), .hit(hit), .tick_out(tick_out)
    );

    lane_spawner #(
        .WIDTH(8), .COL_W(3), .PERIOD_BASE(4), .MIN_GAP(2),
        .CAR_LEN(2), .DENSITY(128), .DIR(1)
    ) dut_r (
        .clock(clock), .reset(reset), .enable(enable), .rand_in(rand_in),
        .speed_sel(speed_sel), .frog_col(frog_col), .frog_in_lane(frog_in_lane),
        .row(row_r), .hit(hit_r), .tick_out(tick_out_r)
    );

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed=0x%0h expected=0x%0h", tag, obs, exp);
        end
    endtask

    task automatic step();
        @(posedge clock);
        #1;
    endtask

    // Returns the number of clock edges until tick_out is seen high.
    task automatic wait_tick(output int n);
        n = 0;
        do begin
            step();
            n++;
        end while (!tick_out && n < 100);
        if (!tick_out) check("tick_timeout", {31'd0, tick_out}, 32'd1);
    endtask

    logic [7:0] exp_rows [8] = '{8'h00, 8'h00, 8'h80, 8'hC0, 8'h60, 8'h30, 8'h98, 8'hCC};
    logic [7:0] exp_rerun [4] = '{8'h00, 8'h00, 8'h80, 8'hC0};
    logic [7:0] exp_rerun_r [4] = '{8'h00, 8'h00, 8'h01, 8'h03};

    initial begin
        int n;

        // Reset, then frozen with enable low
        reset = 1'b1; enable = 1'b0; speed_sel = 2'd3; rand_in = 16'h0000;
        frog_col = 3'd0; frog_in_lane = 1'b0;
        repeat (3) step();
        reset = 1'b0;
        check("reset_row", {24'd0, row}, 32'h00);
        check("reset_hit", {31'd0, hit}, 32'd0);
        check("reset_tick", {31'd0, tick_out}, 32'd0);
        for (int i = 0; i < 20; i++) begin
            step();
            check("frozen_tick", {31'd0, tick_out}, 32'd0);
        end
        check("frozen_row", {24'd0, row}, 32'h00);

        // Fast lane, always-spawn random word; hit checks while row is C0
        enable = 1'b1;
        for (int k = 0; k < 8; k++) begin
            wait_tick(n);
            check("period_fast", n, (k == 4) ? 32'd1 : 32'd4);
            check("row_tick", {24'd0, row}, {24'd0, exp_rows[k]});
            if (k == 3) begin
                frog_col = 3'd6; frog_in_lane = 1'b1;
                step();
                check("hit_on_car", {31'd0, hit}, 32'd1);
                frog_in_lane = 1'b0;
                step();
                check("hit_not_in_lane", {31'd0, hit}, 32'd0);
                frog_in_lane = 1'b1; frog_col = 3'd5;
                step();
                check("hit_empty_col", {31'd0, hit}, 32'd0);
                frog_in_lane = 1'b0;
            end
        end
        check("row_dir1_mirror", {24'd0, row_r}, 32'h33);

        // Never-spawn word at slowest speed; speed change waits for next period
        rand_in = 16'hFFFF; speed_sel = 2'd0;
        wait_tick(n);
        check("period_before_relatch", n, 32'd4);
        check("row_drain", {24'd0, row}, 32'h66);
        for (int i = 0; i < 19; i++) begin
            wait_tick(n);
            check("period_slow", n, 32'd16);
        end
        check("row_no_spawn", {24'd0, row}, 32'h00);
        rand_in = 16'h0000; speed_sel = 2'd3;
        wait_tick(n);
        check("period_slow_last", n, 32'd16);
        check("row_saturated_spawn", {24'd0, row}, 32'h80);

        // Freeze at div_cnt=2, then speed change mid-period
        step(); step();
        enable = 1'b0;
        for (int i = 0; i < 10; i++) begin
            step();
            check("pause_tick", {31'd0, tick_out}, 32'd0);
        end
        check("pause_row", {24'd0, row}, 32'h80);
        speed_sel = 2'd1;
        enable = 1'b1;
        wait_tick(n);
        check("resume_period", n, 32'd2);
        check("resume_row", {24'd0, row}, 32'hC0);
        wait_tick(n);
        check("period_speed1", n, 32'd12);
        check("row_speed1", {24'd0, row}, 32'h60);

        // Fresh run, then reset mid-car
        speed_sel = 2'd3;
        reset = 1'b1;
        step();
        reset = 1'b0;
        for (int k = 0; k < 3; k++) begin
            wait_tick(n);
            check("rerun_period", n, 32'd4);
            check("rerun_row", {24'd0, row}, {24'd0, exp_rerun[k]});
        end
        frog_col = 3'd7; frog_in_lane = 1'b1; reset = 1'b1;
        step();
        check("midcar_reset_row", {24'd0, row}, 32'h00);
        check("midcar_reset_row_r", {24'd0, row_r}, 32'h00);
        check("midcar_reset_hit", {31'd0, hit}, 32'd0);
        check("midcar_reset_tick", {31'd0, tick_out}, 32'd0);
        reset = 1'b0; frog_in_lane = 1'b0;
        for (int k = 0; k < 4; k++) begin
            wait_tick(n);
            check("post_reset_period", n, 32'd4);
            check("post_reset_row", {24'd0, row}, {24'd0, exp_rerun[k]});
            check("post_reset_row_r", {24'd0, row_r}, {24'd0, exp_rerun_r[k]});
        end

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
`default_nettype wire

// File: doc/lane_spawner.md
Name: lane_spawner

Overview:
- Consumer of the 16-bit LFSR random word (generator) for one road/river lane of the Frogger playfield.
- Maintains a WIDTH-column occupancy row and shifts it one column per movement tick. Uses random bits to decide when a new car enters, enforcing a minimum gap and a fixed car length.
- Flags a collision when the frog stands on an occupied column of this lane.
- Row output drives the LED-matrix renderer.

Parameters:
WIDTH, 16, lane columns (row width)
COL_W, 4, width of frog_col; WIDTH <= 2**COL_W
PERIOD_BASE, 12500000, base tick period in clock cycles (benches use 4)
MIN_GAP, 3, minimum empty columns between cars (0..15)
CAR_LEN, 2, occupied columns per car (1..15)
DENSITY, 96, spawn threshold compared against rand_in[7:0] (0..256)
DIR, 0, 0: insert at bit WIDTH-1, shift toward bit 0; 1: insert at bit 0, shift toward WIDTH-1

Ports:
clock  in  1  system clock
reset  in  1  synchronous, active-high reset
enable  in  1  1 = lane runs; 0 = freeze divider, FSM and row
rand_in  in  16  random word from generator, sampled on tick cycles only
speed_sel  in  2  lane speed, 0 slowest .. 3 fastest
frog_col  in  COL_W  frog column index
frog_in_lane  in  1  frog currently on this lane's row
row  out  WIDTH  lane occupancy, 1 = car
hit  out  1  registered collision flag
tick_out  out  1  one-cycle pulse, high in the cycle the row has just shifted

Behaviour:
- Reset (clock edge with reset=1):
  - row=0, hit=0, tick_out=0.
  - div_cnt=0, state=GAP, gap_cnt=0, run_cnt=0.
  - limit = PERIOD_BASE*(4-speed_sel), latched from the current speed_sel.
- Reset has priority over every other input. Reset mid-car discards the car entirely; no partial state survives.
- Divider:
  - When enable=1, div_cnt increments each cycle.
  - When div_cnt==limit-1, the tick event fires: div_cnt<=0 and limit is re-latched from speed_sel. A speed change therefore takes effect from the next period only.
  - When enable=0, div_cnt, limit, row and FSM all hold, and tick_out=0.
- tick_out is registered: it is 1 in the cycle after the tick edge, i.e. the same cycle the new row value is visible. It is otherwise 0.
- On a tick event, row shifts by one column per DIR and the new bit is inserted at the entry end; the bit shifted out is dropped.
- Inserted bit, from FSM state:
  - GAP, when gap_cnt>=MIN_GAP and rand_in[7:0]<DENSITY:
    - insert 1, run_cnt<=1.
    - If CAR_LEN==1, stay in GAP with gap_cnt<=0; otherwise go to CAR.
  - GAP, otherwise: insert 0, gap_cnt<=min(gap_cnt+1,15) (saturating).
  - CAR: insert 1, run_cnt<=run_cnt+1. When run_cnt+1==CAR_LEN, go to GAP with gap_cnt<=0.
- Boundary values:
  - DENSITY=0: never spawns.
  - DENSITY=256: spawns whenever the gap is satisfied.
  - MIN_GAP=0: spawn is allowed on the tick right after a car ends.
- rand_in is ignored outside tick cycles and in CAR state.
- hit: registered every clock edge, independent of enable and tick.
  - hit <= frog_in_lane & row[frog_col], using the current (pre-edge) row. Latency is 1 cycle.
  - frog_col>=WIDTH gives hit<=0.
- No arithmetic overflow:
  - div_cnt is sized by clog2(4*PERIOD_BASE).
  - gap_cnt and run_cnt are 4 bits.

Test Plan (WIDTH=8, COL_W=3, PERIOD_BASE=4, MIN_GAP=2, CAR_LEN=2, DENSITY=128, DIR=0 unless noted):
- Reset held 3 cycles, then released with enable=0 -> row=0x00, hit=0, tick_out=0; row unchanged for 20 cycles.
- enable=1, speed_sel=3, rand_in=0x0000 -> tick_out pulses every 4 cycles. Row after ticks 1..8 is 00,00,80,C0,60,30,98,CC.
- rand_in=0xFFFF, speed_sel=0 -> tick_out every 16 cycles, row stays 0x00 across 20 ticks. Then rand_in=0x0000 -> first 1 is inserted on the very next tick (gap saturated).
- Row=0xC0, frog_col=6, frog_in_lane=1 -> hit=1 on the following cycle. frog_in_lane=0 -> hit=0 next cycle. frog_col=5 -> hit=0.
- enable dropped for 10 cycles at div_cnt=2 -> row and tick_out frozen. On re-enable, the tick fires 2 cycles later. speed_sel changed 3->1 mid-period -> the current period remains 4 and the next is 12.
- Reset asserted in CAR state right after the tick-3 insert -> next cycle row=0x00, hit=0. After release with rand_in=0x0000, the first car appears on tick 3 again. Repeat the run with DIR=1 -> row after tick 4 is 0x03.
